dmem_responder: RTL

// - Data-side responder for the memory stage: consumes mread/mwrite requests, returns load data on rd.
// - Drives a single-outstanding valid/addr_ok/data_ok bus toward the D-cache/uncached path.
// - Stalls the pipeline until the response arrives and buffers it until the M stage advances.
// - Discards in-flight transactions killed by exception flush.
// - Sits between the memory stage and the dbus port of the core top.

---
 rtl/dmem_responder_if.sv | 51 +++++
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Memory-stage request structs and the single-outstanding data bus of the
// data-side responder.
// Bus handshake: dreq_valid is held with stable dreq_* fields until a cycle
// in which dresp_addr_ok=1 (request accepted). The transaction then ends on
// the first cycle with dresp_data_ok=1, which may be the acceptance cycle
// itself. Load data is valid on dresp_data only together with dresp_data_ok.
interface dmem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
  } mem_read_req_t;

  typedef struct packed {
    logic                valid;
    logic [ADDR_W-1:0]   addr;
    logic [2:0]          size;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strobe;
  } mem_write_req_t;

  mem_read_req_t       mread;
  mem_write_req_t      mwrite;

  logic                dreq_valid;
  logic                dreq_write;
  logic [ADDR_W-1:0]   dreq_addr;
  logic [2:0]          dreq_size;
  logic [DATA_W/8-1:0] dreq_strobe;
  logic [DATA_W-1:0]   dreq_data;
  logic                dresp_addr_ok;
  logic                dresp_data_ok;
  logic [DATA_W-1:0]   dresp_data;

  // Responder side: takes pipeline requests, drives the bus request.
  modport master (
    input  mread, mwrite,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    output dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_data
  );

  // Environment side: pipeline request source plus the cache/uncached path.
  modport slave (
    output mread, mwrite,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    input  dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_data
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-side responder for the memory stage. Issues one outstanding bus
// transaction per load/store, stalls the pipeline until the response is
// held, and drains transactions killed by a flush.
// Optional feature: define DMEM_ALIGN_CHECK_EN to keep misaligned requests
// off the bus (they complete immediately with rd=0).
module dmem_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m_advance,
  input  logic              flush,
  dmem_responder_if.master  bus,
  output logic [DATA_W-1:0] rd,
  output logic              stall_o,
  output logic [CNT_W-1:0]  busy_cycles,
  output logic [2:0]        dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              state;
  logic                discard_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          size_q;
  logic [DATA_W/8-1:0] strobe_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   rd_q;
  logic [CNT_W-1:0]    busy_q;

  logic                req;
  logic                kill;
  logic                in_write;
  logic [ADDR_W-1:0]   in_addr;
  logic [2:0]          in_size;
  logic [DATA_W/8-1:0] in_strobe;
  logic                misaligned;

  assign req       = (bus.mread.valid | bus.mwrite.valid) & ~flush;
  assign kill      = discard_q | flush;
  assign in_write  = bus.mwrite.valid;
  assign in_addr   = in_write ? bus.mwrite.addr : bus.mread.addr;
  assign in_size   = in_write ? bus.mwrite.size : bus.mread.size;
  assign in_strobe = in_write ? bus.mwrite.strobe : '0;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = ((in_size == 3'd1) && in_addr[0]) ||
                      ((in_size == 3'd2) && (|in_addr[1:0]));
`else
  assign misaligned = 1'b0;
`endif

  assign stall_o     = req & (state != S_HOLD);
  assign rd          = rd_q;
  assign busy_cycles = busy_q;
  assign dbg_state   = state;

  // Bus request: straight from the pipeline in IDLE, from latched copies in REQ.
  always_comb begin
    bus.dreq_valid  = 1'b0;
    bus.dreq_write  = write_q;
    bus.dreq_addr   = addr_q;
    bus.dreq_size   = size_q;
    bus.dreq_strobe = strobe_q;
    bus.dreq_data   = data_q;
    if (state == S_IDLE) begin
      bus.dreq_valid  = req & ~misaligned;
      bus.dreq_write  = in_write;
      bus.dreq_addr   = in_addr;
      bus.dreq_size   = in_size;
      bus.dreq_strobe = in_strobe;
      bus.dreq_data   = bus.mwrite.data;
    end else if (state == S_REQ) begin
      bus.dreq_valid  = 1'b1;
    end
  end

  // Transaction FSM; a killed transaction still runs to data_ok, then drops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      discard_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      strobe_q  <= '0;
      data_q    <= '0;
      rd_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            write_q   <= in_write;
            addr_q    <= in_addr;
            size_q    <= in_size;
            strobe_q  <= in_strobe;
            data_q    <= bus.mwrite.data;
            discard_q <= 1'b0;
            if (misaligned) begin
              state <= S_HOLD;
              rd_q  <= '0;
            end else if (bus.dresp_addr_ok && bus.dresp_data_ok) begin
              state <= S_HOLD;
              if (!in_write) rd_q <= bus.dresp_data;
            end else if (bus.dresp_addr_ok) begin
              state <= S_WAIT;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.dresp_addr_ok) begin
            discard_q <= 1'b0;
            if (bus.dresp_data_ok) begin
              if (kill) begin
                state <= S_IDLE;
              end else begin
                state <= S_HOLD;
                if (!write_q) rd_q <= bus.dresp_data;
              end
            end else begin
              state <= kill ? S_DRAIN : S_WAIT;
            end
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.dresp_data_ok) begin
            if (flush) begin
              state <= S_IDLE;
            end else begin
              state <= S_HOLD;
              if (!write_q) rd_q <= bus.dresp_data;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.dresp_data_ok) state <= S_IDLE;
        end
        S_HOLD: begin
          if (m_advance || flush) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Saturating count of pipeline stall cycles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q <= '0;
    end else if (stall_o && (busy_q != {CNT_W{1'b1}})) begin
      busy_q <= busy_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Protocol checks: one request kind at a time, data_ok only for a live transaction.
  a_one_req : assert property (@(posedge clk) disable iff (!resetn)
    !(bus.mread.valid && bus.mwrite.valid));
  a_idle_data_ok : assert property (@(posedge clk) disable iff (!resetn)
    !((state == S_IDLE) && bus.dresp_data_ok && !(bus.dreq_valid && bus.dresp_addr_ok)));
  a_hold_data_ok : assert property (@(posedge clk) disable iff (!resetn)
    !((state == S_HOLD) && bus.dresp_data_ok));
endmodule
